div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller for the integer divider behind DIV/DIVU. It accepts an operand pair from the execute stage, runs an iterative restoring division over several cycles, and publishes quotient to LO and remainder to HI with a one-cycle done pulse. Its busy output goes to the hazard unit, which stalls MFHI/MFLO and any further divides until the result is ready. It replaces the single-cycle divide in the execute stage.

Parameters:
WIDTH, 32, operand/result width in bits
STEPS, 1, quotient bits resolved per cycle; legal values 1, 2, 4; must divide WIDTH

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request: execute stage holds a divide (HasDivE and not FlushE)
is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
dividend  in  WIDTH  rs value; sampled with start
divisor  in  WIDTH  rt value; sampled with start
flush  in  1  abort any in-flight divide (hazard unit flush)
busy  out  1  operation in flight; stall source for the hazard unit
done  out  1  one-cycle pulse; hi_out/lo_out valid from this cycle on
hi_out  out  WIDTH  remainder
lo_out  out  WIDTH  quotient

Behaviour:
- Reset (reset high at a clock edge): state IDLE; busy=0, done=0, hi_out=0, lo_out=0, iteration counter=0. Takes effect from any state, including mid-ITER.
- States: IDLE, ITER, FIX, DONE.
- IDLE: on start, latch |dividend| and |divisor| (magnitudes only when is_signed=1, else raw values), both operand signs, is_signed and a divisor-zero flag. Clear the partial remainder, load the count with WIDTH/STEPS, go to ITER. busy=1 from the next cycle.
- ITER: each cycle performs STEPS restoring steps: shift the remainder left and bring in the next dividend MSB; if remainder >= divisor magnitude, subtract it and set the quotient bit to 1, else set it to 0. Decrement the count; go to FIX when the count reaches 1.
- FIX: apply signs (signed only). Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
- Divisor zero (checked in FIX): lo=all-ones and hi=raw dividend, for both signed and unsigned. This overrides the sign fix.
- FIX then writes hi_out/lo_out and goes to DONE.
- DONE: done=1 for exactly this one cycle, busy=0, then go to IDLE. A start arriving in DONE is accepted, exactly as in IDLE.
- Latency: start at cycle 0, done at cycle WIDTH/STEPS+1. With the defaults this is cycle 33.
- busy is high in ITER and FIX only.
- hi_out/lo_out hold their last result until the next FIX, or until reset.
- A start while busy is ignored; the hazard unit must never issue one.
- flush in ITER or FIX: go to IDLE at the next edge. No done pulse; hi_out/lo_out keep their previous values.
- flush and start in the same cycle: flush wins and the start is dropped.
- Signed overflow (0x80000000 / -1) is handled by the magnitude path: lo=0x80000000, hi=0.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: at start, if the divisor is zero or |dividend| < |divisor|, skip ITER and go straight to FIX. The quotient is then 0 (or all-ones for divisor zero) and the remainder is the dividend. done arrives at cycle 2.
- Not defined: every divide takes the full WIDTH/STEPS+1 cycles, including divide-by-zero.

Decomposition:
- Package div_pkg: state enum (IDLE, ITER, FIX, DONE), default WIDTH and STEPS, DIV_ZERO_QUOT constant (all-ones), counter-width function clog2(WIDTH/STEPS+1).
- Sub-module div_step: purely combinational single restoring step (remainder in, dividend bit in, divisor in → remainder out, quotient bit out). It is instantiated STEPS times in a chain inside div_sequencer.

Test Plan:
1. DIVU, dividend=100, divisor=7 → done at cycle 33 (defaults), lo=14, hi=2; busy high on cycles 1..32.
2. DIV, dividend=0xFFFFFFF9 (-7), divisor=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
3. DIV, dividend=0x80000000, divisor=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIV, dividend=5, divisor=0 → lo=0xFFFFFFFF, hi=5. done at cycle 33 without DIV_EARLY_OUT_EN, at cycle 2 with it.
5. Start 100/7, assert flush at cycle 10 → busy=0 at cycle 11, no done pulse, hi/lo keep the prior result. Then start 9/3 → lo=3, hi=0.
6. Assert reset at cycle 5 of a divide → next cycle busy=0, done=0, hi_out=0, lo_out=0. A start on the following cycle completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU sequencer.
package div_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = 1;

  // Wide enough for any WIDTH up to 64; users slice the low WIDTH bits.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  function automatic int cnt_w(input int width, input int steps);
    return $clog2(width / steps + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // Remainder stays below the divisor, so the true difference always fits WIDTH bits.
  assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
  assign o_q     = (w_shift >= {1'b0, i_dvs});
  assign o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];
endmodule

// File: rtl/div_sequencer.sv
// Iterative DIV/DIVU controller: STEPS restoring steps per cycle, quotient to LO, remainder to HI.
// Optional macro DIV_EARLY_OUT_EN skips iteration for zero divisor or |dividend| < |divisor|.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = DEF_STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int NITER = WIDTH / STEPS;
  localparam int CW    = cnt_w(WIDTH, STEPS);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dvd, r_hi, r_lo;
  logic             r_a_neg, r_b_neg, r_dvz, r_early, r_busy, r_done;

  logic             w_a_neg, w_b_neg, w_early;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quo_next, w_q_mag, w_r_mag, w_lo_fix, w_hi_fix;
  logic [STEPS:0][WIDTH-1:0] w_rem_c;
  logic [STEPS-1:0] w_qbits;

  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (divisor == '0) | (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // r_quo starts as the dividend magnitude; its MSBs feed the chain while quotient bits shift in at the LSB.
  assign w_rem_c[0] = r_rem;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (w_rem_c[g]),
      .i_bit (r_quo[WIDTH-1-g]),
      .i_dvs (r_dvs),
      .o_rem (w_rem_c[g+1]),
      .o_q   (w_qbits[STEPS-1-g])
    );
  end
  assign w_quo_next = (r_quo << STEPS) | WIDTH'(w_qbits);

  // FIX runs the final step group itself, so ITER lasts NITER-1 cycles.
  assign w_q_mag  = r_early ? '0    : w_quo_next;
  assign w_r_mag  = r_early ? r_quo : w_rem_c[STEPS];
  assign w_lo_fix = r_dvz ? DIV_ZERO_QUOT[WIDTH-1:0] : ((r_a_neg ^ r_b_neg) ? -w_q_mag : w_q_mag);
  assign w_hi_fix = r_dvz ? r_dvd : (r_a_neg ? -w_r_mag : w_r_mag);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_dvd   <= '0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_dvz   <= 1'b0;
      r_early <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_dvd   <= dividend;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_dvz   <= (divisor == '0);
            r_early <= w_early;
            r_cnt   <= CW'(NITER);
            r_busy  <= 1'b1;
            r_state <= w_early ? FIX : ITER;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        ITER: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_c[STEPS];
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(2)) r_state <= FIX;
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes model results, a negedge monitor checks each done pulse.
module tb_div_sequencer;
  logic        clock, reset, start, is_signed, flush;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_sequencer #(.WIDTH(32), .STEPS(1)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint la, lb, lq, lr;
    if (b == 0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      return;
    end
    la = s ? longint'($signed(a)) : longint'({32'b0, a});
    lb = s ? longint'($signed(b)) : longint'({32'b0, b});
    lq = la / lb;
    lr = la % lb;
    lo = lq[31:0];
    hi = lr[31:0];
  endfunction

  function automatic int lat(input logic [31:0] a, input logic [31:0] b, input bit s);
`ifdef DIV_EARLY_OUT_EN
    longint la, lb;
    la = s ? longint'($signed(a)) : longint'({32'b0, a});
    lb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
    if (b == 0 || la < lb) return 2;
`else
    if (a === 32'hx || b === 32'hx || s === 1'bx) return 0;
`endif
    return 33;
  endfunction

  // Called at #1 after a posedge; start is held for exactly that cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
    exp_t e;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    if (push) begin
      model(a, b, s, e.hi, e.lo);
      e.cyc = cyc + lat(a, b, s);
      sb.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s);
    issue(a, b, s, 1'b1);
    wait_done();
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=done required=idle hi=%h lo=%h", hi_out, lo_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo_out", lo_out, e.lo);
        chk("hi_out", hi_out, e.hi);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int nb;
    logic [31:0] a, b;
    bit s;
    reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // DIVU 100/7 with busy profile across cycles 1..33
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    nb = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1) nb++;
      @(posedge clock); #1;
    end
    chk("t1_busy_iter_errs", 32'(nb), 32'd0);
    chk("t1_busy_at_done", {31'b0, busy}, 32'd0);
    chk("t1_done_at_33", {31'b0, done}, 32'd1);

    run(32'hFFFF_FFF9, 32'd2, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'd5, 32'd0, 1'b1);
    run(32'd5, 32'd0, 1'b0);
    @(posedge clock); #1;

    // flush at cycle 10 together with a start that must be dropped
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clock); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_hi_kept", hi_out, last_hi);
    chk("flush_lo_kept", lo_out, last_lo);
    repeat (40) begin @(posedge clock); #1; end
    chk("flush_still_idle", {31'b0, busy}, 32'd0);
    run(32'd9, 32'd3, 1'b0);
    @(posedge clock); #1;

    // reset in the middle of a divide
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    run(32'd1000, 32'd33, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 16);
        3:       b = 32'($signed(-$urandom_range(1, 300)));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
      end
      run(a, b, s);
    end

    repeat (5) begin @(posedge clock); #1; end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
